mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port word memory (Mem) between the CPU instruction-fetch port (I) and
//  load/store port (D). Owns the only Mem command bus; one transaction in flight at a time.
//  D has priority; a streak limiter bounds I starvation. Sits between CPU core and Mem.
// PARAMETERS
//  MAX_D_STREAK  4  consecutive D grants allowed while I_Req is high before I is forced
//  STREAK_W      3  width of streak counter; must hold MAX_D_STREAK
// PORTS
//  Clk          in   1   system clock, all state on posedge
//  Reset        in   1   asynchronous, active-high
//  I_Req        in   1   fetch request; held with I_Addr until I_Ack
//  I_Addr       in   30  word address [31:2]
//  I_Data       out  32  fetched word; valid only while I_Ack=1
//  I_Ack        out  1   one-cycle completion pulse for I
//  D_Req        in   1   load/store request; fields held until D_Ack
//  D_RW         in   1   1=store, 0=load
//  D_BE         in   4   byte enables; legal: 4'b1111, 4'b0011, 4'b0001
//  D_Addr       in   30  word address [31:2]
//  D_WData      in   32  store data
//  D_RData      out  32  load data; valid only while D_Ack=1 and D_RW was 0
//  D_Ack        out  1   one-cycle completion pulse for D
//  D_Err        out  1   with D_Ack: illegal D_BE, access not performed
//  M_CS         out  1   Mem chip select
//  M_RW         out  1   Mem write strobe (1=write)
//  M_BE         out  4   Mem byte enables
//  M_Addr       out  30  Mem word address
//  M_DataIn     out  32  Mem write data
//  M_DataOut    in   32  Mem registered read data
//  M_DataReady  in   1   Mem ready; completion stalls while 0
// BEHAVIOUR
//  Reset: state=IDLE, owner=D, streak=0; M_CS=M_RW=0, M_BE=0, M_Addr=0, M_DataIn=0,
//   I_Ack=D_Ack=D_Err=0. Reset mid-transaction drops it silently; requesters re-issue.
//  FSM: IDLE -> ISSUE -> DONE -> IDLE.
//   IDLE: if any Req, choose winner, latch its addr/BE/RW/wdata into command regs, set owner,
//    -> ISSUE. I transactions use BE=4'b1111, RW=0. No Req: stay.
//   ISSUE (1 cycle): M_CS=1, M_Addr/M_BE/M_DataIn from command regs, M_RW=latched RW.
//    Mem executes on the posedge ending ISSUE. -> DONE.
//   DONE: M_CS=0, M_RW=0. Ack owner when M_DataReady=1 (stay in DONE while 0), then -> IDLE.
//    I_Data/D_RData = M_DataOut passed through; Ack is combinational from state, owner,
//    M_DataReady.
//  M_RW must be 0 in every state except ISSUE-of-store: Mem does not qualify writes with CS.
//  Latency: Req high in cycle 0 (state IDLE) -> ISSUE in cycle 1 -> Ack in cycle 2. Next grant
//   at the earliest in cycle 3; a Req held through its Ack cycle is a new request.
//  Arbitration (in IDLE only): only one Req -> it wins. Both -> D wins unless
//   streak==MAX_D_STREAK, then I wins.
//   streak: +1 (saturating) on D grant while I_Req=1; cleared on I grant or when I_Req=0 in IDLE.
//  Illegal D_BE: granted normally but ISSUE drives M_CS=0, M_RW=0 (no Mem access).
//   DONE acks with D_Err=1 and D_RData=0. Streak counts it as a D grant.
//  Req dropped before Ack: protocol violation; the latched transaction completes regardless.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE/ISSUE/DONE), OWNER_I/OWNER_D, legal BE constants,
//   be_legal() function.
//  Sub-module mem_arb_prio: combinational winner select plus streak counter register.
//  Top: FSM, command registers, Mem drive, ack/data steering.
// TESTING
//  1 D store addr 5, BE=1111, data 32'hDEADBEEF; then D load addr 5 -> D_Ack in cycle 2 each;
//    load returns 32'hDEADBEEF; M_RW=1 only in store ISSUE cycle.
//  2 I_Req and D_Req held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I;
//    each Ack 3 cycles apart.
//  3 D load BE=0011 from word holding 32'h12345678 -> D_RData=32'h00005678; D_BE=0101 ->
//    D_Err=1, D_RData=0, M_CS never asserted, memory unchanged.
//  4 M_DataReady held 0 for 3 cycles in DONE -> Ack delayed exactly 3 cycles; data correct;
//    no second Mem access.
//  5 Reset pulsed during ISSUE of a store -> all outputs at reset values next cycle; no Ack
//    issued; after re-request, store completes normally.
//  6 Only I_Req, 8 back-to-back fetches addrs 0..7 -> I_Ack every 3rd cycle; streak stays 0;
//    M_RW never 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_WORD) || (be == BE_HALF) || (be == BE_BYTE);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch (I) and load/store (D), with a D-streak limiter
// that forces an I grant after MAX_D_STREAK consecutive D wins while I waits.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   arbEn,
  input  logic   iReq,
  input  logic   dReq,
  output logic   grantValid,
  output owner_t winner
);

  logic [STREAK_W-1:0] streak;
  logic                forceI;

  always_comb begin
    forceI     = (streak == STREAK_W'(MAX_D_STREAK));
    grantValid = iReq | dReq;
    winner     = OWNER_D;
    if (iReq && (!dReq || forceI)) winner = OWNER_I;
  end

  // Only IDLE-cycle decisions move the streak; a waiting-free I side resets it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      streak <= '0;
    end else if (arbEn) begin
      if (!iReq || (winner == OWNER_I)) streak <= '0;
      else if (dReq && (streak != '1)) streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between CPU fetch (I) and load/store (D);
// one transaction in flight, D preferred, I starvation bounded by a streak limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        I_Req,
  input  logic [29:0] I_Addr,
  output logic [31:0] I_Data,
  output logic        I_Ack,
  input  logic        D_Req,
  input  logic        D_RW,
  input  logic [3:0]  D_BE,
  input  logic [29:0] D_Addr,
  input  logic [31:0] D_WData,
  output logic [31:0] D_RData,
  output logic        D_Ack,
  output logic        D_Err,
  output logic        M_CS,
  output logic        M_RW,
  output logic [3:0]  M_BE,
  output logic [29:0] M_Addr,
  output logic [31:0] M_DataIn,
  input  logic [31:0] M_DataOut,
  input  logic        M_DataReady
);

  arb_state_t  state, stateNext;
  owner_t      owner, winner;
  logic        grantValid, grant, done;
  logic [29:0] cmdAddr;
  logic [3:0]  cmdBe;
  logic        cmdRw, cmdIllegal;
  logic [31:0] cmdWData;

  mem_arb_prio #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .STREAK_W    (STREAK_W)
  ) uPrio (
    .Clk       (Clk),
    .Reset     (Reset),
    .arbEn     (state == ST_IDLE),
    .iReq      (I_Req),
    .dReq      (D_Req),
    .grantValid(grantValid),
    .winner    (winner)
  );

  assign grant = (state == ST_IDLE) && grantValid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      owner <= OWNER_D;
    end else begin
      state <= stateNext;
      if (grant) owner <= winner;
    end
  end

  // Command registers are only observed outside IDLE, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (grant) begin
      if (winner == OWNER_I) begin
        cmdAddr    <= I_Addr;
        cmdBe      <= BE_WORD;
        cmdRw      <= 1'b0;
        cmdWData   <= '0;
        cmdIllegal <= 1'b0;
      end else begin
        cmdAddr    <= D_Addr;
        cmdBe      <= D_BE;
        cmdRw      <= D_RW;
        cmdWData   <= D_WData;
        cmdIllegal <= !be_legal(D_BE);
      end
    end
  end

  always_comb begin
    stateNext = state;
    M_CS      = 1'b0;
    M_RW      = 1'b0;
    M_BE      = '0;
    M_Addr    = '0;
    M_DataIn  = '0;
    unique case (state)
      ST_IDLE:  if (grantValid) stateNext = ST_ISSUE;
      ST_ISSUE: begin
        stateNext = ST_DONE;
        M_BE      = cmdBe;
        M_Addr    = cmdAddr;
        M_DataIn  = cmdWData;
        // Mem writes on RW alone, so an illegal access must gate both strobes.
        M_CS      = !cmdIllegal;
        M_RW      = cmdRw && !cmdIllegal;
      end
      ST_DONE:  if (M_DataReady) stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  assign done    = (state == ST_DONE) && M_DataReady;
  assign I_Ack   = done && (owner == OWNER_I);
  assign D_Ack   = done && (owner == OWNER_D);
  assign D_Err   = D_Ack && cmdIllegal;
  assign I_Data  = M_DataOut;
  assign D_RData = cmdIllegal ? 32'h0 : M_DataOut;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enable word memory model.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        I_Req = 1'b0;
  logic [29:0] I_Addr = '0;
  logic [31:0] I_Data;
  logic        I_Ack;
  logic        D_Req = 1'b0;
  logic        D_RW = 1'b0;
  logic [3:0]  D_BE = 4'hF;
  logic [29:0] D_Addr = '0;
  logic [31:0] D_WData = '0;
  logic [31:0] D_RData;
  logic        D_Ack;
  logic        D_Err;
  logic        M_CS;
  logic        M_RW;
  logic [3:0]  M_BE;
  logic [29:0] M_Addr;
  logic [31:0] M_DataIn;
  logic [31:0] M_DataOut = '0;
  logic        M_DataReady = 1'b1;

  int errors = 0;
  int checks = 0;
  int csCnt = 0, rwCnt = 0, dAckCnt = 0;
  logic [31:0] mem [64];

  mem_port_arbiter #(.MAX_D_STREAK(4), .STREAK_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Data(I_Data), .I_Ack(I_Ack),
    .D_Req(D_Req), .D_RW(D_RW), .D_BE(D_BE), .D_Addr(D_Addr), .D_WData(D_WData),
    .D_RData(D_RData), .D_Ack(D_Ack), .D_Err(D_Err),
    .M_CS(M_CS), .M_RW(M_RW), .M_BE(M_BE), .M_Addr(M_Addr), .M_DataIn(M_DataIn),
    .M_DataOut(M_DataOut), .M_DataReady(M_DataReady)
  );

  always #5 Clk = ~Clk;

  // Memory model: writes on M_RW regardless of M_CS, reads return BE-masked word.
  always @(posedge Clk) begin
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (M_BE[b]) mask[8*b +: 8] = 8'hFF;
    if (M_RW)
      mem[M_Addr[5:0]] <= (mem[M_Addr[5:0]] & ~mask) | (M_DataIn & mask);
    if (M_CS && !M_RW) M_DataOut <= mem[M_Addr[5:0]] & mask;
  end

  always @(negedge Clk) begin
    if (M_CS) csCnt++;
    if (M_RW) rwCnt++;
    if (D_Ack) dAckCnt++;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h11110000 + i;
    mem[9]  = 32'h12345678;
    mem[20] = 32'h0;
  end

  task automatic dXact(input logic rw, input logic [3:0] be, input logic [29:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic err);
    @(negedge Clk);
    D_Req = 1'b1; D_RW = rw; D_BE = be; D_Addr = addr; D_WData = wd;
    lat = -1; rd = 'x; err = 1'bx;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge Clk); #1;
      if (D_Ack) begin lat = k; rd = D_RData; err = D_Err; end
    end
    D_Req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({M_CS, M_RW, M_BE, M_Addr, M_DataIn, I_Ack, D_Ack, D_Err} !== '0)
      begin errors++; $display("FAIL reset_outputs: got cs=%0b rw=%0b be=%h addr=%h din=%h ia=%0b da=%0b de=%0b, want all 0",
        M_CS, M_RW, M_BE, M_Addr, M_DataIn, I_Ack, D_Ack, D_Err); end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (dut.uPrio.streak !== 3'd0) begin errors++; $display("FAIL reset_streak: got %0d want 0", dut.uPrio.streak); end
  endtask

  task automatic test_fetch_stream();
    int n = 0, rw0 = rwCnt;
    int cyc[8];
    @(negedge Clk);
    I_Req = 1'b1; I_Addr = 30'd0;
    for (int k = 1; k <= 60 && n < 8; k++) begin
      @(negedge Clk); #1;
      if (I_Ack) begin
        cyc[n] = k;
        checks++;
        if (I_Data !== 32'h11110000 + n) begin errors++; $display("FAIL fetch_data[%0d]: got %h want %h", n, I_Data, 32'h11110000 + n); end
        checks++;
        if (dut.uPrio.streak !== 3'd0) begin errors++; $display("FAIL fetch_streak[%0d]: got %0d want 0", n, dut.uPrio.streak); end
        n++;
        if (n == 8) I_Req = 1'b0; else I_Addr = 30'(n);
      end
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL fetch_count: got %0d want 8", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cyc[i] !== 2 + 3 * i) begin errors++; $display("FAIL fetch_cycle[%0d]: got %0d want %0d", i, cyc[i], 2 + 3 * i); end
    end
    checks++;
    if (rwCnt - rw0 !== 0) begin errors++; $display("FAIL fetch_no_write: got %0d write cycles want 0", rwCnt - rw0); end
  endtask

  task automatic test_store_load();
    int lat, rw0;
    logic [31:0] rd;
    logic err;
    rw0 = rwCnt;
    dXact(1'b1, 4'b1111, 30'd5, 32'hDEADBEEF, lat, rd, err);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d want 2", lat); end
    checks++;
    if (rwCnt - rw0 !== 1) begin errors++; $display("FAIL store_rw_cycles: got %0d want 1", rwCnt - rw0); end
    rw0 = rwCnt;
    dXact(1'b0, 4'b1111, 30'd5, 32'h0, lat, rd, err);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d want 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h want DEADBEEF", rd); end
    checks++;
    if (rwCnt - rw0 !== 0) begin errors++; $display("FAIL load_rw_cycles: got %0d want 0", rwCnt - rw0); end
  endtask

  task automatic test_byte_enables();
    int lat, cs0;
    logic [31:0] rd;
    logic err;
    dXact(1'b0, 4'b0011, 30'd9, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h00005678) begin errors++; $display("FAIL half_load_data: got %h want 00005678", rd); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL half_load_err: got %0b want 0", err); end
    cs0 = csCnt;
    dXact(1'b1, 4'b0101, 30'd9, 32'hFFFFFFFF, lat, rd, err);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d want 2", lat); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %0b want 1", err); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL illegal_rdata: got %h want 0", rd); end
    checks++;
    if (csCnt - cs0 !== 0) begin errors++; $display("FAIL illegal_cs: got %0d cs cycles want 0", csCnt - cs0); end
    checks++;
    if (mem[9] !== 32'h12345678) begin errors++; $display("FAIL illegal_mem: got %h want 12345678", mem[9]); end
  endtask

  task automatic test_ready_stall();
    int cs0 = csCnt;
    int ackAt = -1;
    logic [31:0] rd = '0;
    @(negedge Clk);
    M_DataReady = 1'b0;
    D_Req = 1'b1; D_RW = 1'b0; D_BE = 4'hF; D_Addr = 30'd9;
    for (int k = 1; k <= 8 && ackAt < 0; k++) begin
      @(negedge Clk);
      if (k == 5) M_DataReady = 1'b1;
      #1;
      if (D_Ack) begin ackAt = k; rd = D_RData; end
    end
    D_Req = 1'b0; M_DataReady = 1'b1;
    checks++;
    if (ackAt !== 5) begin errors++; $display("FAIL stall_latency: got %0d want 5", ackAt); end
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL stall_data: got %h want 12345678", rd); end
    checks++;
    if (csCnt - cs0 !== 1) begin errors++; $display("FAIL stall_cs: got %0d cs cycles want 1", csCnt - cs0); end
  endtask

  task automatic test_reset_mid_store();
    int lat, ack0;
    logic [31:0] rd;
    logic err;
    @(negedge Clk);
    D_Req = 1'b1; D_RW = 1'b1; D_BE = 4'hF; D_Addr = 30'd20; D_WData = 32'hCAFEF00D;
    @(negedge Clk); #1;
    checks++;
    if (M_RW !== 1'b1) begin errors++; $display("FAIL rst_issue_rw: got %0b want 1", M_RW); end
    ack0 = dAckCnt;
    Reset = 1'b1; D_Req = 1'b0;
    #1;
    checks++;
    if ({M_CS, M_RW, M_BE, M_Addr, M_DataIn, D_Ack, D_Err} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got cs=%0b rw=%0b be=%h addr=%h din=%h, want all 0", M_CS, M_RW, M_BE, M_Addr, M_DataIn); end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if (dAckCnt - ack0 !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d acks want 0", dAckCnt - ack0); end
    checks++;
    if (mem[20] !== 32'h0) begin errors++; $display("FAIL rst_no_write: got %h want 0", mem[20]); end
    dXact(1'b1, 4'hF, 30'd20, 32'hCAFEF00D, lat, rd, err);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rst_restore_latency: got %0d want 2", lat); end
    dXact(1'b0, 4'hF, 30'd20, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_restore_data: got %h want CAFEF00D", rd); end
  endtask

  task automatic test_back_to_back();
    logic isI[10];
    int cyc[10];
    int n = 0;
    @(negedge Clk);
    I_Req = 1'b1; I_Addr = 30'd1;
    D_Req = 1'b1; D_RW = 1'b0; D_BE = 4'hF; D_Addr = 30'd5;
    for (int k = 1; k <= 60 && n < 10; k++) begin
      @(negedge Clk); #1;
      if (D_Ack || I_Ack) begin
        isI[n] = I_Ack; cyc[n] = k; n++;
        if (n == 10) begin I_Req = 1'b0; D_Req = 1'b0; end
      end
    end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (isI[i] !== (i == 4 || i == 9)) begin errors++; $display("FAIL b2b_owner[%0d]: got I=%0b want I=%0b", i, isI[i], (i == 4 || i == 9)); end
      checks++;
      if (cyc[i] !== 2 + 3 * i) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, cyc[i], 2 + 3 * i); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_store_load();
    test_byte_enables();
    test_ready_stall();
    test_reset_mid_store();
    test_back_to_back();
    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
